// File: rtl/pulse_mon_pkg.sv
// Shared types and helpers for the tick period monitor: FSM states, interval
// classes, window bounds and the interval classifier.
package pulse_mon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACQ,
        ST_TRACK,
        ST_LOCKED,
        ST_FAULT
    } pulse_state_e;

    typedef enum logic [1:0] {
        CL_NONE,
        CL_EARLY,
        CL_INWIN,
        CL_LATE
    } ival_class_e;

    // Expected period is n+1; the accepted window is [n+1-tol, n+1+tol].
    function automatic int unsigned win_lo(input int unsigned n, input int unsigned tol);
        return n + 1 - tol;
    endfunction

    function automatic int unsigned win_hi(input int unsigned n, input int unsigned tol);
        return n + 1 + tol;
    endfunction

    // A real tick is classified by the current count, even when it lands on
    // the late threshold; without a tick, only the threshold itself is late.
    function automatic ival_class_e classify(input logic [31:0]  c,
                                             input logic         tick,
                                             input int unsigned  lo,
                                             input int unsigned  hi);
        ival_class_e cls;
        cls = CL_NONE;
        if (tick) begin
            if (c < lo)
                cls = CL_EARLY;
            else if (c <= hi)
                cls = CL_INWIN;
            else
                cls = CL_LATE;
        end else if (c == hi + 1) begin
            cls = CL_LATE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/pulse_interval_ctr.sv
// Saturating interval counter: clear to 0, load to 1, or count up and hold at
// all-ones. Clear beats load, load beats increment.
module pulse_interval_ctr #(
    parameter int CBITS = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load1,
    input  logic             inc,
    output logic [CBITS-1:0] c
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            c <= '0;
        else if (load1)
            c <= CBITS'(1);
        else if (inc && (c != '1))
            c <= c + CBITS'(1);
    end

endmodule

// File: rtl/pulse_period_monitor.sv
// Tick period monitor: measures tick-to-tick intervals, classifies them against
// the expected period and tracks lock / fault with a registered-output FSM.
module pulse_period_monitor
    import pulse_mon_pkg::*;
#(
    parameter int N        = 10000,
    parameter int CBITS    = 14,
    parameter int TOL      = 2,
    parameter int LOCK_CNT = 3,
    parameter int MISS_MAX = 2,
    parameter int MBITS    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    output logic             locked,
    output logic             fault,
    output logic             early,
    output logic             late,
    output logic [MBITS-1:0] miss_cnt,
    output logic [CBITS-1:0] ival,
    output pulse_state_e     state
);

    localparam int unsigned LO      = win_lo(N, TOL);
    localparam int unsigned HI      = win_hi(N, TOL);
    localparam int unsigned LATE_TH = HI + 1;
    localparam int          GBITS   = $clog2(LOCK_CNT + 1);

    generate
        if ((LATE_TH > (2 ** CBITS) - 1) || (TOL > N + 1)) begin : g_width_chk
            $error("pulse_period_monitor: window bounds do not fit in CBITS");
        end
    endgenerate

    pulse_state_e      state_q, state_d;
    logic [GBITS-1:0]  good_q, good_d;
    logic [MBITS-1:0]  miss_d, miss_inc;
    logic [CBITS-1:0]  ival_d, c;
    logic              early_d, late_d;
    logic              ctr_clr, ctr_load, ctr_inc;
    ival_class_e       cls;

    pulse_interval_ctr #(.CBITS(CBITS)) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctr_clr),
        .load1 (ctr_load),
        .inc   (ctr_inc),
        .c     (c)
    );

    assign state = state_q;

    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        miss_d   = miss_cnt;
        ival_d   = ival;
        early_d  = 1'b0;
        late_d   = 1'b0;
        ctr_clr  = 1'b0;
        ctr_load = 1'b0;
        ctr_inc  = 1'b0;
        cls      = classify(32'(c), tick, LO, HI);
        miss_inc = (miss_cnt == '1) ? miss_cnt : miss_cnt + MBITS'(1);

        if (!en) begin
            state_d = ST_IDLE;
            good_d  = '0;
            miss_d  = '0;
            ival_d  = '0;
            ctr_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    good_d  = '0;
                    miss_d  = '0;
                    ival_d  = '0;
                    ctr_clr = 1'b1;
                    state_d = ST_ACQ;
                end
                ST_ACQ: begin
                    ctr_inc = 1'b1;
                    if (tick) begin
                        ctr_load = 1'b1;
                        state_d  = ST_TRACK;
                    end
                end
                default: begin
                    // TRACK, LOCKED and FAULT all measure and strobe; a late
                    // event acts as a virtual tick and restarts the interval.
                    ctr_inc  = 1'b1;
                    ctr_load = (cls != CL_NONE);
                    early_d  = (cls == CL_EARLY);
                    late_d   = (cls == CL_LATE);
                    if (tick)
                        ival_d = c;

                    if (state_q == ST_TRACK) begin
                        if (cls == CL_INWIN) begin
                            if (32'(good_q) + 1 == LOCK_CNT) begin
                                state_d = ST_LOCKED;
                                good_d  = '0;
                            end else begin
                                good_d = good_q + GBITS'(1);
                            end
                        end else if (cls == CL_EARLY) begin
                            good_d = '0;
                        end else if (cls == CL_LATE) begin
                            good_d  = '0;
                            state_d = ST_ACQ;
                        end
                    end else if (state_q == ST_LOCKED) begin
                        if (cls == CL_INWIN) begin
                            miss_d = '0;
                        end else if (early_d || late_d) begin
                            miss_d = miss_inc;
                            if (32'(miss_inc) == 32'(MISS_MAX))
                                state_d = ST_FAULT;
                        end
                    end else if (early_d || late_d) begin
                        miss_d = miss_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            good_q   <= '0;
            miss_cnt <= '0;
            ival     <= '0;
            early    <= 1'b0;
            late     <= 1'b0;
            locked   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            state_q  <= state_d;
            good_q   <= good_d;
            miss_cnt <= miss_d;
            ival     <= ival_d;
            early    <= early_d;
            late     <= late_d;
            locked   <= (state_d == ST_LOCKED);
            fault    <= (state_d == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pulse_period_monitor.sv
// Scoreboarded bench for pulse_period_monitor: a tick-timestamp reference model
// predicts the registered status each cycle; a monitor pops and compares.
module tb_pulse_period_monitor;
    import pulse_mon_pkg::*;

    localparam int N        = 8;
    localparam int CBITS    = 5;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 3;
    localparam int MISS_MAX = 2;
    localparam int MBITS    = 4;
    localparam int P        = N + 1;
    localparam int LO       = P - TOL;
    localparam int HI       = P + TOL;
    localparam int VW       = 4 + MBITS + CBITS;

    // clock / reset
    logic clk = 1'b0;
    logic rst, en, tick;
    logic locked, fault, early, late;
    logic [MBITS-1:0] miss_cnt;
    logic [CBITS-1:0] ival;
    pulse_state_e     state;

    always #5 clk = ~clk;

    pulse_period_monitor #(
        .N(N), .CBITS(CBITS), .TOL(TOL),
        .LOCK_CNT(LOCK_CNT), .MISS_MAX(MISS_MAX), .MBITS(MBITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .tick     (tick),
        .locked   (locked),
        .fault    (fault),
        .early    (early),
        .late     (late),
        .miss_cnt (miss_cnt),
        .ival     (ival),
        .state    (state)
    );

    // reference model: mode 0 idle, 1 acquire, 2 track, 3 locked, 4 fault
    int m_mode = 0, m_last = 0, m_good = 0, m_miss = 0, m_ival = 0, m_cyc = 0;
    bit m_early, m_late;
    logic [VW-1:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    task automatic model_step(input logic e, input logic t, input logic r);
        int d;
        bit is_e, is_w, is_l;
        m_early = 1'b0;
        m_late  = 1'b0;
        m_cyc++;
        if (r || !e) begin
            m_mode = 0; m_good = 0; m_miss = 0; m_ival = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (t) begin
                m_last = m_cyc;
                m_mode = 2;
            end
        end else begin
            d    = m_cyc - m_last;
            is_e = t && (d < LO);
            is_w = t && (d >= LO) && (d <= HI);
            is_l = (t && (d > HI)) || (!t && (d == HI + 1));
            if (t) m_ival = d;
            if (is_e || is_w || is_l) m_last = m_cyc;
            m_early = is_e;
            m_late  = is_l;
            if (m_mode == 2) begin
                if (is_w) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin
                        m_mode = 3;
                        m_good = 0;
                    end
                end else if (is_e) begin
                    m_good = 0;
                end else if (is_l) begin
                    m_good = 0;
                    m_mode = 1;
                end
            end else if (is_w && m_mode == 3) begin
                m_miss = 0;
            end else if (is_e || is_l) begin
                if (m_miss < (2 ** MBITS) - 1) m_miss++;
                if (m_mode == 3 && m_miss == MISS_MAX) m_mode = 4;
            end
        end
        exp_q.push_back({m_mode == 3, m_mode == 4, m_early, m_late,
                         MBITS'(m_miss), CBITS'(m_ival)});
    endtask

    // driver tasks
    task automatic step(input logic e, input logic t, input logic r);
        @(negedge clk);
        en   = e;
        tick = t;
        rst  = r;
        model_step(e, t, r);
    endtask

    task automatic gap(input int k);
        repeat (k - 1) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
    endtask

    // scoreboard monitor
    logic [VW-1:0] exp_v, got_v;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {locked, fault, early, late, miss_cnt, ival};
                n_vec++;
                if (got_v !== exp_v) begin
                    n_miss++;
                    $display("FAIL status t=%0t got lk=%0b ft=%0b e=%0b l=%0b miss=%0d ival=%0d exp lk=%0b ft=%0b e=%0b l=%0b miss=%0d ival=%0d",
                             $time, got_v[VW-1], got_v[VW-2], got_v[VW-3], got_v[VW-4],
                             got_v[CBITS +: MBITS], got_v[CBITS-1:0],
                             exp_v[VW-1], exp_v[VW-2], exp_v[VW-3], exp_v[VW-4],
                             exp_v[CBITS +: MBITS], exp_v[CBITS-1:0]);
                end
            end
        end
    end

    // stimulus
    initial begin
        int r;
        rst  = 1'b1;
        en   = 1'b0;
        tick = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0);

        // acquire and lock at period 9, then one early tick and recovery
        step(1'b1, 1'b1, 1'b0);
        repeat (5) gap(9);
        gap(6);
        gap(9);

        // ticks stop: repeated lates, fault, miss_cnt saturates
        repeat (170) step(1'b1, 1'b0, 1'b0);

        // leave fault via en, relock at period 10
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (5) gap(10);

        // track with good=2, out-of-window tick at 11, then resume
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        gap(9);
        gap(9);
        gap(11);
        repeat (5) gap(9);

        // reset coincident with a tick while locked
        repeat (8) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (4) gap(9);

        // randomized intervals with occasional enable drops and resets
        repeat (300) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)
                step(1'b0, 1'b0, 1'b0);
            else if (r < 5)
                step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
            else if (r < 55)
                gap(int'($urandom_range(8, 10)));
            else
                gap(int'($urandom_range(4, 14)));
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pulse_period_monitor.md
Name: pulse_period_monitor

Overview:
- Downstream consumer of the periodic delay/tick stage. Watches its one-cycle `sig` pulse, here the `tick` input.
- Measures each tick-to-tick interval, classifies it as in-window, early or late, and tracks lock with a small FSM.
- Drives lock/fault status and per-tick error strobes to system control and to formal checkers. Liveness properties of the form "eventually always locked unless reset recurs" apply to this block.

Parameters:
- N, 10000, upstream delay constant; expected period P = N+1 cycles.
- CBITS, 14, interval counter width; must satisfy 2^CBITS-1 >= P+TOL+1.
- TOL, 2, accepted deviation in cycles; window is [P-TOL, P+TOL].
- LOCK_CNT, 3, consecutive in-window intervals needed to lock.
- MISS_MAX, 2, consecutive misses in LOCKED that cause FAULT.
- MBITS, 4, width of miss_cnt.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- en  in  1  monitor enable; low forces IDLE
- tick  in  1  one-cycle pulse from upstream delay stage
- locked  out  1  high while state==LOCKED
- fault  out  1  high while state==FAULT
- early  out  1  one-cycle strobe: last tick arrived before P-TOL
- late  out  1  one-cycle strobe: no tick by P+TOL
- miss_cnt  out  MBITS  consecutive misses, saturating at 2^MBITS-1
- ival  out  CBITS  last measured interval in cycles

Behaviour:
- All outputs are registered. Reset values: locked=0, fault=0, early=0, late=0, miss_cnt=0, ival=0. Internal state is IDLE, interval counter c=0, good=0.
- rst wins over every other input in the same cycle.
- Interval counter c:
  - In ACQ, TRACK and LOCKED, c increments each cycle and saturates at all-ones.
  - On an accepted tick or a late event, c loads 1, so the next tick sees interval = c.
  - Measured interval at a tick = current c. It is registered to ival one cycle later.
- Classification, evaluated only in TRACK and LOCKED:
  - tick with c < P-TOL -> early.
  - tick with P-TOL <= c <= P+TOL -> in-window.
  - no tick and c == P+TOL+1 -> late. This is a virtual tick: c reloads 1.
  - tick and the late threshold in the same cycle -> treat as a tick, classified by c.
  - early/late strobes assert for exactly one cycle, one cycle after the event.
- FSM states: IDLE, ACQ, TRACK, LOCKED, FAULT.
  - IDLE: c=0, good=0, miss_cnt=0. en=1 -> ACQ.
  - ACQ: waits for the first tick; no classification, late never fires. On tick: c:=1 -> TRACK.
  - TRACK: in-window tick -> good++; when good reaches LOCK_CNT -> LOCKED and good:=0. Early or late -> ACQ with good:=0. After an early tick, c:=1 and that tick counts as the new first tick, so the FSM goes straight to TRACK rather than ACQ.
  - LOCKED: in-window tick -> miss_cnt:=0. Early or late -> miss_cnt++; if the new value == MISS_MAX -> FAULT.
  - FAULT: sticky. Only rst or en=0 leaves it (-> IDLE). early/late still strobe; miss_cnt saturates.
  - en=0 in any state -> IDLE next cycle; counters clear and strobes deassert.
  - tick while IDLE is ignored.
- Width rules:
  - All comparisons are unsigned at CBITS.
  - P-TOL and P+TOL+1 are elaboration-time constants; elaboration asserts that both fit in CBITS.
  - miss_cnt does not wrap.

Decomposition:
- Package pulse_mon_pkg holds:
  - state enum type;
  - localparam helpers for window low/high bounds;
  - a function classify(c, tick) returning {NONE, EARLY, INWIN, LATE}.
- One sub-module, pulse_interval_ctr: saturating counter with load-1, enable and clear; exposes c.
- The FSM and output registers live in the top.

Test Plan:
All scenarios use N=8 (P=9), TOL=1, LOCK_CNT=3, MISS_MAX=2, CBITS=5.
- Ticks every 9 cycles after rst release and en=1 -> locked rises one cycle after the 4th tick (first tick + 3 in-window); ival=9; no early/late.
- Locked, then a tick arrives 6 cycles after the previous one -> early=1 for one cycle, ival=6, miss_cnt=1, locked stays 1. Next tick 9 cycles later -> miss_cnt=0.
- Locked, then ticks stop -> late strobes when c reaches 11 (P+TOL+1). With no further ticks, late repeats 10 cycles later, then fault=1, locked=0.
- TRACK (good=2) with the next tick at 11 cycles (out of window) -> late strobe, FSM to ACQ, no lock. Resume period 9 -> lock after 4 further ticks.
- FAULT, then en=0 for 1 cycle -> IDLE, all outputs 0. en=1 with ticks every 10 cycles (in window) -> relocks.
- rst asserted mid-LOCKED in the same cycle as a tick -> next cycle all outputs 0, state IDLE, the tick is ignored.
